// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Shares one single-port 32-bit on-chip RAM between two Avalon-style masters:
// M0 (CPU data) and M1 (pixel/DMA engine). A hold-limited round-robin FSM
// picks the granted master each cycle. The granted master's address,
// byteenable and writedata pass combinationally to the RAM. Read data comes
// back one cycle later with a per-master readdatavalid. Addresses at or above
// MEM_DEPTH never reach the RAM. Out-of-range accesses and requests that
// assert read and write together are recorded in sticky error flags.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   mN_address            17-bit word address from master N
//   mN_byteenable         byte lanes from master N
//   mN_read / mN_write    request strobes from master N
//   mN_writedata          write data from master N
//   mN_waitrequest        high = master N's request not accepted this cycle
//   mN_readdata           read data returned to master N (held between reads)
//   mN_readdatavalid      one-cycle pulse marking valid mN_readdata
//   mem_*                 RAM interface (registered address, unregistered q)
//   mem_readdata          RAM q
//   err_clear             synchronous clear of err
//   err                   sticky: [0] out-of-range, [1] read+write together
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int          MEM_DEPTH      = 100000,
  parameter int          MAX_HOLD       = 4,
  parameter logic [31:0] OOR_READ_VALUE = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [16:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [16:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  input  logic        err_clear,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [17:0] DEPTH_C    = 18'(MEM_DEPTH);
  localparam logic [3:0]  MAX_HOLD_C = 4'(MAX_HOLD);

  state_t      state_q, state_d;
  logic        rrPtr_q, rrPtr_d;
  logic [3:0]  holdCnt_q, holdCnt_d;
  logic [1:0]  err_q, err_d;
  logic        rdValid0_q, rdValid1_q;
  logic        rdOor_q;
  logic [31:0] rdHold0_q, rdHold1_q;

  logic        req0, req1;
  logic        grantValid, grantSel;
  logic [16:0] selAddress;
  logic        selRead, selWrite;
  logic        inRange;
  logic        acceptRead;
  logic [31:0] rdData;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant decision. While reset is asserted nothing is granted so the RAM
  // sees no chipselect and both masters are stalled.
  always_comb begin
    grantValid = 1'b0;
    grantSel   = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            grantValid = 1'b1;
            grantSel   = rrPtr_q;
          end else if (req0) begin
            grantValid = 1'b1;
            grantSel   = 1'b0;
          end else if (req1) begin
            grantValid = 1'b1;
            grantSel   = 1'b1;
          end
        end
        OWN0: begin
          if (req0 && ((holdCnt_q < MAX_HOLD_C) || !req1)) begin
            grantValid = 1'b1;
            grantSel   = 1'b0;
          end else if (req1) begin
            grantValid = 1'b1;
            grantSel   = 1'b1;
          end
        end
        OWN1: begin
          if (req1 && ((holdCnt_q < MAX_HOLD_C) || !req0)) begin
            grantValid = 1'b1;
            grantSel   = 1'b1;
          end else if (req0) begin
            grantValid = 1'b1;
            grantSel   = 1'b0;
          end
        end
        default: begin
          grantValid = 1'b0;
          grantSel   = 1'b0;
        end
      endcase
    end
  end

  // Path from the granted master to the RAM.
  assign selAddress     = grantSel ? m1_address : m0_address;
  assign selRead        = grantSel ? m1_read    : m0_read;
  assign selWrite       = grantSel ? m1_write   : m0_write;
  assign inRange        = ({1'b0, selAddress} < DEPTH_C);
  // Read+write together is handled as a write, so it never returns data.
  assign acceptRead     = grantValid & selRead & ~selWrite;

  assign mem_address    = selAddress;
  assign mem_byteenable = grantSel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grantSel ? m1_writedata  : m0_writedata;
  assign mem_chipselect = grantValid & inRange;
  assign mem_write      = mem_chipselect & selWrite;
  assign mem_clken      = 1'b1;

  // A requester that lost arbitration stalls; idle masters see 0.
  assign m0_waitrequest = reset | (req0 & ~(grantValid & ~grantSel));
  assign m1_waitrequest = reset | (req1 & ~(grantValid &  grantSel));

  // Next-state logic: every accept moves ownership to the granted master and
  // points round-robin at the other one; an idle cycle returns to IDLE.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    holdCnt_d = holdCnt_q;
    if (grantValid) begin
      state_d = grantSel ? OWN1 : OWN0;
      rrPtr_d = ~grantSel;
      if (state_d != state_q) begin
        holdCnt_d = 4'd1;
      end else if (holdCnt_q != 4'hF) begin
        holdCnt_d = holdCnt_q + 4'd1;
      end
    end else begin
      state_d   = IDLE;
      holdCnt_d = 4'd0;
    end
  end

  // Sticky errors. A new error in the same cycle as err_clear wins.
  always_comb begin
    err_d = err_clear ? 2'b00 : err_q;
    if (grantValid && !inRange) begin
      err_d[0] = 1'b1;
    end
    if (grantValid && selRead && selWrite) begin
      err_d[1] = 1'b1;
    end
  end

  // Out-of-range reads never touched the RAM, so they return a constant.
  assign rdData           = rdOor_q ? OOR_READ_VALUE : mem_readdata;
  assign m0_readdatavalid = rdValid0_q;
  assign m1_readdatavalid = rdValid1_q;
  assign m0_readdata      = rdValid0_q ? rdData : rdHold0_q;
  assign m1_readdata      = rdValid1_q ? rdData : rdHold1_q;
  assign err              = err_q;

  // Arbiter state, read-return tracking and held read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= 1'b0;
      holdCnt_q  <= 4'd0;
      err_q      <= 2'b00;
      rdValid0_q <= 1'b0;
      rdValid1_q <= 1'b0;
      rdOor_q    <= 1'b0;
      rdHold0_q  <= 32'h0;
      rdHold1_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      holdCnt_q  <= holdCnt_d;
      err_q      <= err_d;
      rdValid0_q <= acceptRead & ~grantSel;
      rdValid1_q <= acceptRead &  grantSel;
      rdOor_q    <= ~inRange;
      rdHold0_q  <= m0_readdata;
      rdHold1_q  <= m1_readdata;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//
// Directed bench for onchip_mem_arbiter with a small behavioural RAM, a
// transaction-level reference model and a per-cycle compare process, plus
// literal expectations for the main scenarios.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int          MEM_DEPTH = 100000;
  localparam int          MAX_HOLD  = 4;
  localparam logic [31:0] OOR_VAL   = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [16:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [16:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        err_clear;
  logic [1:0]  err;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(
    .MEM_DEPTH(MEM_DEPTH), .MAX_HOLD(MAX_HOLD), .OOR_READ_VALUE(OOR_VAL)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .err_clear(err_clear), .err(err)
  );

  // Initial RAM contents: easy to recognise per address.
  function automatic logic [31:0] pattern(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Behavioural RAM: registered address, unregistered q, byte-lane writes.
  logic [31:0] ram [0:255];
  logic [7:0]  ramAddrQ = 8'd0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      ramAddrQ <= mem_address[7:0];
    end
  end
  assign mem_readdata = ram[ramAddrQ];

  // Reference model: who owns the RAM, how long it has owned it, whose turn
  // it is after an idle, what each master should currently see as read data.
  logic [31:0] shadow [0:255];
  int          mOwner  = -1;
  int          mStreak = 0;
  int          mRr     = 0;
  logic        mValid0 = 1'b0, mValid1 = 1'b0;
  logic [31:0] mData0 = 32'h0, mData1 = 32'h0;
  logic [1:0]  mErr = 2'b00;

  function automatic logic [16:0] gAddr(input int g);
    return (g == 1) ? m1_address : m0_address;
  endfunction
  function automatic logic gRead(input int g);
    return (g == 1) ? m1_read : m0_read;
  endfunction
  function automatic logic gWrite(input int g);
    return (g == 1) ? m1_write : m0_write;
  endfunction
  function automatic logic [3:0] gBe(input int g);
    return (g == 1) ? m1_byteenable : m0_byteenable;
  endfunction
  function automatic logic [31:0] gWd(input int g);
    return (g == 1) ? m1_writedata : m0_writedata;
  endfunction

  // Which master is served this cycle (-1 = none).
  function automatic int expGrant();
    logic r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset || (!r0 && !r1)) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (mOwner < 0) return mRr;
    return (mStreak < MAX_HOLD) ? mOwner : 1 - mOwner;
  endfunction

  always @(posedge clk or posedge reset) begin : modelUpdate
    int          g;
    logic [16:0] a;
    logic        rd, wr, oor;
    logic [31:0] val, merged, wd;
    logic [3:0]  be;
    logic [1:0]  nerr;
    if (reset) begin
      mOwner  <= -1;
      mStreak <= 0;
      mRr     <= 0;
      mValid0 <= 1'b0;
      mValid1 <= 1'b0;
      mData0  <= 32'h0;
      mData1  <= 32'h0;
      mErr    <= 2'b00;
    end else begin
      g = expGrant();
      nerr = err_clear ? 2'b00 : mErr;
      mValid0 <= 1'b0;
      mValid1 <= 1'b0;
      if (g >= 0) begin
        a   = gAddr(g);
        rd  = gRead(g);
        wr  = gWrite(g);
        oor = (int'(a) >= MEM_DEPTH);
        if (oor) nerr[0] = 1'b1;
        if (rd && wr) nerr[1] = 1'b1;
        if (rd && !wr) begin
          val = oor ? OOR_VAL : shadow[a[7:0]];
          if (g == 0) begin
            mValid0 <= 1'b1;
            mData0  <= val;
          end else begin
            mValid1 <= 1'b1;
            mData1  <= val;
          end
        end
        if (wr && !oor) begin
          merged = shadow[a[7:0]];
          wd = gWd(g);
          be = gBe(g);
          for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
          end
          shadow[a[7:0]] <= merged;
        end
        mStreak <= (g == mOwner) ? mStreak + 1 : 1;
        mOwner  <= g;
        mRr     <= 1 - g;
      end else begin
        mOwner  <= -1;
        mStreak <= 0;
      end
      mErr <= nerr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare
    int   g;
    logic ew0, ew1, ecs;
    g   = expGrant();
    ew0 = reset | ((m0_read | m0_write) && g != 0);
    ew1 = reset | ((m1_read | m1_write) && g != 1);
    ecs = (g >= 0) && (int'(gAddr(g)) < MEM_DEPTH);
    checkOutput("m0_waitrequest", m0_waitrequest, ew0);
    checkOutput("m1_waitrequest", m1_waitrequest, ew1);
    checkOutput("mem_chipselect", mem_chipselect, ecs);
    checkOutput("mem_write", mem_write, ecs & gWrite(g));
    if (ecs) begin
      checkOutput("mem_address", mem_address, gAddr(g));
      if (gWrite(g)) begin
        checkOutput("mem_writedata", mem_writedata, gWd(g));
        checkOutput("mem_byteenable", mem_byteenable, gBe(g));
      end
    end
    checkOutput("m0_readdatavalid", m0_readdatavalid, mValid0);
    checkOutput("m1_readdatavalid", m1_readdatavalid, mValid1);
    checkOutput("m0_readdata", m0_readdata, mData0);
    checkOutput("m1_readdata", m1_readdata, mData1);
    checkOutput("err", err, mErr);
    checkOutput("mem_clken", mem_clken, 1);
  end

  task automatic applyStimulus(input int m, input logic rd, input logic wr,
                               input logic [16:0] a, input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  // One transfer on master m; returns #1 after the accepting edge.
  task automatic doXfer(input int m, input logic rd, input logic wr,
                        input logic [16:0] a, input logic [3:0] be, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    applyStimulus(m, rd, wr, a, be, d);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
      @(posedge clk);
      #1;
    end
    applyStimulus(m, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
    checkOutput("xfer_accepted", acc, 1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int order[$];
  int idx0, idx1, guard;
  logic a0, a1;
  int expOrder[16] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
  int rdv0Cnt = 0, rdv1Cnt = 0;
  int base0, base1;

  always @(negedge clk) begin
    if (m0_readdatavalid) rdv0Cnt <= rdv0Cnt + 1;
    if (m1_readdatavalid) rdv1Cnt <= rdv1Cnt + 1;
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = pattern(i);
      shadow[i] = pattern(i);
    end
    applyStimulus(0, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
    err_clear = 1'b0;
    #1 reset = 1'b1;
    idleCycles(2);
    @(negedge clk);
    checkOutput("rst_wait0", m0_waitrequest, 1);
    checkOutput("rst_wait1", m1_waitrequest, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    idleCycles(1);

    $display("[TB] write then read on M0");
    doXfer(0, 1'b0, 1'b1, 17'h10, 4'hF, 32'hA5A5A5A5);
    doXfer(0, 1'b1, 1'b0, 17'h10, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("t1_rdv0", m0_readdatavalid, 1);
    checkOutput("t1_rdata0", m0_readdata, 32'hA5A5A5A5);
    checkOutput("t1_rdv1", m1_readdatavalid, 0);
    @(posedge clk);
    #1;

    $display("[TB] contention with hold limit");
    doXfer(1, 1'b0, 1'b1, 17'h40, 4'hF, 32'h11111111);
    idleCycles(1);
    base0 = rdv0Cnt;
    base1 = rdv1Cnt;
    idx0 = 0; idx1 = 0; guard = 0;
    applyStimulus(0, 1'b1, 1'b0, 17'h20, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 17'h30, 4'hF, 32'h0);
    while ((idx0 < 8 || idx1 < 8) && guard < 100) begin
      @(negedge clk);
      a0 = m0_read && !m0_waitrequest;
      a1 = m1_read && !m1_waitrequest;
      if (a0) order.push_back(0);
      if (a1) order.push_back(1);
      @(posedge clk);
      #1;
      if (a0) begin
        idx0++;
        if (idx0 < 8) applyStimulus(0, 1'b1, 1'b0, 17'(32'h20 + idx0), 4'hF, 32'h0);
        else applyStimulus(0, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
      end
      if (a1) begin
        idx1++;
        if (idx1 < 8) applyStimulus(1, 1'b1, 1'b0, 17'(32'h30 + idx1), 4'hF, 32'h0);
        else applyStimulus(1, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
      end
      guard++;
    end
    checkOutput("t2_finished", guard < 100, 1);
    checkOutput("t2_order_len", order.size(), 16);
    for (int i = 0; i < 16 && i < order.size(); i++) begin
      checkOutput("t2_order", order[i], expOrder[i]);
    end
    idleCycles(2);
    checkOutput("t2_rdv0_count", rdv0Cnt - base0, 8);
    checkOutput("t2_rdv1_count", rdv1Cnt - base1, 8);

    $display("[TB] M1 back-to-back reads");
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) applyStimulus(1, 1'b1, 1'b0, 17'(k), 4'hF, 32'h0);
      else applyStimulus(1, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
      @(negedge clk);
      if (k < 10) checkOutput("t3_nowait", m1_waitrequest, 0);
      checkOutput("t3_rdv1", m1_readdatavalid, k >= 1);
      if (k >= 1) checkOutput("t3_rdata1", m1_readdata, pattern(k - 1));
      @(posedge clk);
      #1;
    end
    idleCycles(1);

    $display("[TB] byte-enable write");
    doXfer(0, 1'b0, 1'b1, 17'h12, 4'hF, 32'h12345678);
    doXfer(0, 1'b0, 1'b1, 17'h12, 4'h1, 32'h000000FF);
    doXfer(0, 1'b1, 1'b0, 17'h12, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("t4_rdv0", m0_readdatavalid, 1);
    checkOutput("t4_rdata0", m0_readdata, 32'h123456FF);
    @(posedge clk);
    #1;

    $display("[TB] out-of-range and error flags");
    checkOutput("t5_err_before", err, 2'b00);
    applyStimulus(0, 1'b1, 1'b0, 17'd100000, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("t5_oor_wait0", m0_waitrequest, 0);
    checkOutput("t5_oor_cs", mem_chipselect, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t5_oor_rdv0", m0_readdatavalid, 1);
    checkOutput("t5_oor_rdata0", m0_readdata, 32'h00000000);
    checkOutput("t5_err_oor", err, 2'b01);
    @(posedge clk);
    #1 err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    @(negedge clk);
    checkOutput("t5_err_cleared", err, 2'b00);
    @(posedge clk);
    #1;
    doXfer(0, 1'b1, 1'b1, 17'h13, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t5_err_rw", err, 2'b10);
    checkOutput("t5_rw_rdv0", m0_readdatavalid, 0);
    @(posedge clk);
    #1 err_clear = 1'b1;
    doXfer(1, 1'b0, 1'b1, 17'd131071, 4'hF, 32'h0);
    err_clear = 1'b0;
    @(negedge clk);
    checkOutput("t5_err_clear_vs_new", err, 2'b01);
    @(posedge clk);
    #1;

    $display("[TB] reset after accepted read");
    doXfer(0, 1'b1, 1'b0, 17'h10, 4'hF, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_rdv0", m0_readdatavalid, 0);
    checkOutput("t6_wait0", m0_waitrequest, 1);
    checkOutput("t6_wait1", m1_waitrequest, 1);
    checkOutput("t6_err", err, 2'b00);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 17'h10, 4'hF, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 17'h11, 4'hF, 32'h0);
    @(negedge clk);
    checkOutput("t6_idle_rr_wait0", m0_waitrequest, 0);
    checkOutput("t6_idle_rr_wait1", m1_waitrequest, 1);
    @(posedge clk);
    #1 applyStimulus(0, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("t6_resume_rdv0", m0_readdatavalid, 1);
    checkOutput("t6_resume_rdata0", m0_readdata, 32'hA5A5A5A5);
    @(posedge clk);
    #1 applyStimulus(1, 1'b0, 1'b0, 17'd0, 4'd0, 32'd0);
    idleCycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
